// File: rtl/router_vc_input_port.sv
// router_vc_input_port
//   Input port of the 5-port mesh router. It holds two virtual channels. VC0
//   takes the flits whose header vc bit is 0 and VC1 takes those with vc=1.
//   Each channel is a DEPTH-deep circular FIFO. The head flit of VC[polarity]
//   is routed XY. The port raises a one-hot request toward the output
//   arbiters and pops the flit on a matching grant. The outgoing flit carries
//   its hop count decremented.
//
// Handshake: upstream pushes on posedge when si=1 and ri[datai vc]=1. A push
//   while ri is low is dropped. Downstream pops on posedge when (req & gnt)!=0.
//   gnt bits outside req are ignored, and req holds until it is granted.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   polarity        router phase; only VC[polarity] may request
//   si, datai       upstream send strobe and flit
//   ri[1:0]         per-VC "can accept" (registered counts only)
//   req[4:0]        one-hot request: 0=E 1=W 2=N 3=S 4=PE
//   gnt[4:0]        grants from the output arbiters
//   datao           head flit of VC[polarity] with the hop field updated (0 if no req)
//   occ0, occ1      registered per-VC occupancy, 0..DEPTH
module router_vc_input_port #(
  parameter int DW    = 64,
  parameter int DEPTH = 4,
  parameter int HW    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       polarity,
  input  logic                       si,
  input  logic [DW-1:0]              datai,
  output logic [1:0]                 ri,
  output logic [4:0]                 req,
  input  logic [4:0]                 gnt,
  output logic [DW-1:0]              datao,
  output logic [$clog2(DEPTH):0]     occ0,
  output logic [$clog2(DEPTH):0]     occ1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [CW-1:0] cnt0, cnt1;

  logic          push0, push1, pop, pop0, pop1;
  logic [DW-1:0] head, head_mod;
  logic          have_head;
  logic [HW-1:0] hx, hy;
  logic [4:0]    route;

  // Acceptance depends only on the registered counts. A full channel refuses
  // a push even when a pop happens in the same cycle.
  assign ri[0] = (cnt0 < CW'(DEPTH));
  assign ri[1] = (cnt1 < CW'(DEPTH));

  assign push0 = si && !datai[DW-1] && ri[0];
  assign push1 = si &&  datai[DW-1] && ri[1];

  // The head comes from registered storage. A flit pushed this cycle cannot
  // fall through to req.
  assign head      = polarity ? mem1[rp1] : mem0[rp0];
  assign have_head = polarity ? (cnt1 != '0) : (cnt0 != '0);
  assign hx        = head[DW-4 -: HW];
  assign hy        = head[DW-4-HW -: HW];

  // XY routing. X is exhausted first, then Y, then the flit ejects to the PE.
  always_comb begin
    route    = 5'b10000;
    head_mod = head;
    if (hx != '0) begin
      route                = head[DW-2] ? 5'b00010 : 5'b00001;
      head_mod[DW-4 -: HW] = hx - HW'(1);
    end else if (hy != '0) begin
      route                   = head[DW-3] ? 5'b01000 : 5'b00100;
      head_mod[DW-4-HW -: HW] = hy - HW'(1);
    end
  end

  // No request while reset is asserted, so the flits about to be discarded
  // cannot be granted.
  assign req   = (have_head && !reset) ? route : 5'b00000;
  assign datao = (req != 5'b00000) ? head_mod : '0;

  assign pop  = |(req & gnt);
  assign pop0 = pop && !polarity;
  assign pop1 = pop &&  polarity;

  always_ff @(posedge clk) begin
    if (!reset && push0) mem0[wp0] <= datai;
    if (!reset && push1) mem1[wp1] <= datai;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp0  <= '0;
      rp0  <= '0;
      cnt0 <= '0;
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) wp0 <= wp0 + AW'(1);
      if (pop0)  rp0 <= rp0 + AW'(1);
      if (push1) wp1 <= wp1 + AW'(1);
      if (pop1)  rp1 <= rp1 + AW'(1);
      case ({push0, pop0})
        2'b10:   cnt0 <= cnt0 + CW'(1);
        2'b01:   cnt0 <= cnt0 - CW'(1);
        default: cnt0 <= cnt0;
      endcase
      case ({push1, pop1})
        2'b10:   cnt1 <= cnt1 + CW'(1);
        2'b01:   cnt1 <= cnt1 - CW'(1);
        default: cnt1 <= cnt1;
      endcase
    end
  end

  assign occ0 = cnt0;
  assign occ1 = cnt1;

endmodule

// File: tb/tb_router_vc_input_port.sv
// Testbench for router_vc_input_port (DW=64, DEPTH=4, HW=4).
// The driver issues directed pushes and grants. When it issues a grant, it
// queues the hand-computed {req, datao}. A negedge monitor pops the queue and
// compares on every cycle where the DUT is granted.
module tb_router_vc_input_port;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int HW    = 4;
  localparam int PW    = DW - 3 - 2*HW;
  localparam int EW    = DW + 5;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          polarity = 1'b0;
  logic          si = 1'b0;
  logic [DW-1:0] datai = '0;
  logic [1:0]    ri;
  logic [4:0]    req;
  logic [4:0]    gnt = 5'b00000;
  logic [DW-1:0] datao;
  logic [2:0]    occ0, occ1;

  router_vc_input_port #(.DW(DW), .DEPTH(DEPTH), .HW(HW)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .si(si), .datai(datai),
    .ri(ri), .req(req), .gnt(gnt), .datao(datao), .occ0(occ0), .occ1(occ1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [DW-1:0] mk(input logic vc, input logic xd, input logic yd,
                                       input logic [HW-1:0] hx, input logic [HW-1:0] hy,
                                       input logic [PW-1:0] pl);
    return {vc, xd, yd, hx, hy, pl};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] f);
    si = 1'b1;
    datai = f;
    step();
    si = 1'b0;
  endtask

  task automatic grant(input logic [4:0] g, input logic [DW-1:0] exp_flit);
    gnt = g;
    exp_q.push_back({g, exp_flit});
    step();
    gnt = 5'b00000;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && ((req & gnt) != 5'b00000)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got req=%0h datao=%0h expected no pop", req, datao);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("pop_flit", {req, datao}, e);
      end
    end
  end

  logic [DW-1:0] b [8];
  logic [DW-1:0] c [5];
  logic [DW-1:0] cm [5];

  initial begin
    // Reset then idle.
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ri",    EW'(ri),    EW'(2'b11));
    chk("rst_req",   EW'(req),   EW'(0));
    chk("rst_occ0",  EW'(occ0),  EW'(0));
    chk("rst_occ1",  EW'(occ1),  EW'(0));
    chk("rst_datao", EW'(datao), EW'(0));

    // A single VC0 east-bound flit: hx 2->1, hy stays 1.
    step();
    polarity = 1'b0;
    push(mk(1'b0, 1'b0, 1'b0, 4'd2, 4'd1, PW'('h111)));
    @(negedge clk);
    chk("e_occ0", EW'(occ0), EW'(1));
    chk("e_req",  EW'(req),  EW'(5'b00001));
    step();
    grant(5'b00001, mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd1, PW'('h111)));
    @(negedge clk);
    chk("e_occ0_after", EW'(occ0), EW'(0));
    chk("e_req_after",  EW'(req),  EW'(0));

    // VC1 fill, overflow drop, and wrap with FIFO order over 8 flits.
    step();
    polarity = 1'b1;
    for (int i = 0; i < 8; i++) b[i] = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, PW'(32'h100 + i));
    for (int i = 0; i < 4; i++) push(b[i]);
    @(negedge clk);
    chk("full_occ1", EW'(occ1), EW'(4));
    chk("full_ri",   EW'(ri),   EW'(2'b01));
    step();
    push(mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, PW'('hdead)));
    @(negedge clk);
    chk("drop_occ1", EW'(occ1), EW'(4));
    step();
    grant(5'b10000, b[0]);
    @(negedge clk);
    chk("pop1_occ1", EW'(occ1), EW'(3));
    step();
    push(b[4]);
    @(negedge clk);
    chk("refill_occ1", EW'(occ1), EW'(4));
    step();
    grant(5'b10000, b[1]);
    for (int i = 5; i < 8; i++) begin
      si = 1'b1;
      datai = b[i];
      grant(5'b10000, b[i-3]);
      si = 1'b0;
    end
    @(negedge clk);
    chk("pp_occ1", EW'(occ1), EW'(3));
    step();
    for (int i = 5; i < 8; i++) grant(5'b10000, b[i]);
    @(negedge clk);
    chk("drain_occ1", EW'(occ1), EW'(0));

    // PE flit in VC0, south flit in VC1; a mismatched grant must not pop.
    step();
    polarity = 1'b0;
    push(mk(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, PW'('h222)));
    push(mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, PW'('h333)));
    @(negedge clk);
    chk("pe_req", EW'(req), EW'(5'b10000));
    step();
    gnt = 5'b00100;
    step();
    gnt = 5'b00000;
    @(negedge clk);
    chk("mis_occ0", EW'(occ0), EW'(1));
    chk("mis_occ1", EW'(occ1), EW'(1));
    step();
    polarity = 1'b1;
    @(negedge clk);
    chk("s_req", EW'(req), EW'(5'b01000));
    step();
    polarity = 1'b0;
    grant(5'b10000, mk(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, PW'('h222)));
    polarity = 1'b1;
    grant(5'b01000, mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, PW'('h333)));
    polarity = 1'b0;

    // VC0 full: push refused during a pop, then push+pop keeps occupancy.
    for (int i = 0; i < 5; i++) begin
      c[i]  = mk(1'b0, 1'b1, 1'b0, 4'd1, 4'd0, PW'(32'h400 + i));
      cm[i] = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, PW'(32'h400 + i));
    end
    for (int i = 0; i < 4; i++) push(c[i]);
    @(negedge clk);
    chk("f0_occ0", EW'(occ0), EW'(4));
    step();
    si = 1'b1;
    datai = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, PW'('hbad));
    gnt = 5'b00010;
    exp_q.push_back({5'b00010, cm[0]});
    @(negedge clk);
    chk("f0_ri", EW'(ri), EW'(2'b10));
    @(posedge clk);
    #1;
    si = 1'b0;
    gnt = 5'b00000;
    @(negedge clk);
    chk("f0_occ_after", EW'(occ0), EW'(3));
    step();
    grant(5'b00010, cm[1]);
    si = 1'b1;
    datai = c[4];
    grant(5'b00010, cm[2]);
    si = 1'b0;
    @(negedge clk);
    chk("pp_occ0", EW'(occ0), EW'(2));
    step();
    grant(5'b00010, cm[3]);
    grant(5'b00010, cm[4]);
    @(negedge clk);
    chk("f0_drain", EW'(occ0), EW'(0));

    // Reset while occ0=3 with req active; stale flits must never appear.
    step();
    for (int i = 0; i < 3; i++) push(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd2, PW'(32'h500 + i)));
    @(negedge clk);
    chk("pre_rst_occ0", EW'(occ0), EW'(3));
    chk("pre_rst_req",  EW'(req),  EW'(5'b00100));
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("in_rst_req", EW'(req), EW'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_occ0", EW'(occ0), EW'(0));
    chk("post_rst_req",  EW'(req),  EW'(0));
    chk("post_rst_ri",   EW'(ri),   EW'(2'b11));
    step();
    push(mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, PW'('heee)));
    @(negedge clk);
    chk("fresh_req", EW'(req), EW'(5'b10000));
    step();
    grant(5'b10000, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, PW'('heee)));
    step();
    step();
    @(negedge clk);
    chk("idle_req",  EW'(req),  EW'(0));
    chk("idle_occ0", EW'(occ0), EW'(0));

    // Final report.
    chk("exp_q_empty", EW'(exp_q.size()), EW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
